// File: rtl/mips_pkg.sv
// Shared fetch-stage definitions: widths, instruction constants, FSM states
// and the IF/ID payload layout.
package mips_pkg;

    localparam int ADDR_W     = 32;
    localparam int INSN_W     = 32;
    localparam int WORD_BYTES = 4;

    localparam logic [ADDR_W-1:0] DEF_RESET_PC  = 32'h0000_0000;
    localparam logic [INSN_W-1:0] DEF_HALT_INSN = 32'h0000_000D;  // MIPS BREAK
    localparam logic [INSN_W-1:0] NOP           = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [INSN_W-1:0] insn;
        logic [ADDR_W-1:0] pc_plus4;
        logic              valid;
    } if_id_t;

    // Instruction addresses must sit on a word boundary.
    function automatic logic is_aligned(input logic [ADDR_W-1:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register. Priority: reset, flush, load, drain, hold.
// Drain drops only the valid bit so the last payload stays visible.
module if_id_reg
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              flush,
    input  logic              drain,
    input  logic [INSN_W-1:0] next_insn,
    input  logic [ADDR_W-1:0] next_pc_plus4,
    output logic [INSN_W-1:0] instruction,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic              valid
);

    if_id_t q;

    // Pipeline register update; anything not selected holds its value.
    always_ff @(posedge clk) begin
        if (!rst) begin
            q <= '{insn: NOP, pc_plus4: '0, valid: 1'b0};
        end else if (flush) begin
            q <= '{insn: NOP, pc_plus4: '0, valid: 1'b0};
        end else if (load) begin
            q <= '{insn: next_insn, pc_plus4: next_pc_plus4, valid: 1'b1};
        end else if (drain) begin
            q.valid <= 1'b0;
        end
    end

    assign instruction = q.insn;
    assign pc_plus4    = q.pc_plus4;
    assign valid       = q.valid;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, next-PC selection, BOOT/RUN/HALT sequencing
// and the IF/ID register. The instruction memory is combinational, so the
// word at imem_address is captured on the same edge that advances the PC.
// Optional: define FETCH_PERF_CNT_EN to add the fetch_count output.
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC  = DEF_RESET_PC,
    parameter logic [INSN_W-1:0] HALT_INSN = DEF_HALT_INSN
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic [INSN_W-1:0] imem_instruction,
    output logic [ADDR_W-1:0] imem_address,
    output logic [INSN_W-1:0] if_id_instruction,
    output logic [ADDR_W-1:0] if_id_pc_plus4,
    output logic              if_id_valid,
    output logic              halted,
    output logic              misaligned
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]       fetch_count
`endif
);

    fetch_state_t      state, state_next;
    logic [ADDR_W-1:0] pc, pc_next, pc_plus4;
    logic [ADDR_W-1:0] redirect_target;
    logic              redirect, target_ok;
    logic              load, flush, drain, set_mis;

    assign imem_address = pc;
    assign pc_plus4     = pc + ADDR_W'(WORD_BYTES);

    // Branch is the older instruction, so it wins over a same-cycle jump.
    assign redirect        = branch_taken | jump;
    assign redirect_target = branch_taken ? branch_target : jump_target;
    assign target_ok       = is_aligned(redirect_target);

    // Next-state / next-PC decode. Redirects beat stall in RUN and HALT;
    // once a misalignment fault is latched only reset leaves HALT.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        load       = 1'b0;
        flush      = 1'b0;
        drain      = 1'b0;
        set_mis    = 1'b0;
        case (state)
            BOOT: begin
                state_next = RUN;
            end
            RUN: begin
                if (redirect) begin
                    flush = 1'b1;
                    if (target_ok) begin
                        pc_next = redirect_target;
                    end else begin
                        set_mis    = 1'b1;
                        state_next = HALT;
                    end
                end else if (!stall) begin
                    load = 1'b1;
                    if (imem_instruction == HALT_INSN) begin
                        state_next = HALT;
                    end else begin
                        pc_next = pc_plus4;
                    end
                end
            end
            HALT: begin
                if (redirect && !misaligned) begin
                    flush = 1'b1;
                    if (target_ok) begin
                        pc_next    = redirect_target;
                        state_next = RUN;
                    end else begin
                        set_mis = 1'b1;
                    end
                end else if (!stall) begin
                    drain = 1'b1;
                end
            end
            default: begin
                state_next = BOOT;
            end
        endcase
    end

    // Fetch FSM: state, PC and the registered status outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= BOOT;
            pc         <= RESET_PC;
            halted     <= 1'b0;
            misaligned <= 1'b0;
        end else begin
            state      <= state_next;
            pc         <= pc_next;
            halted     <= (state_next == HALT);
            misaligned <= misaligned | set_mis;
        end
    end

    if_id_reg u_if_id (
        .clk           (clk),
        .rst           (rst),
        .load          (load),
        .flush         (flush),
        .drain         (drain),
        .next_insn     (imem_instruction),
        .next_pc_plus4 (pc_plus4),
        .instruction   (if_id_instruction),
        .pc_plus4      (if_id_pc_plus4),
        .valid         (if_id_valid)
    );

`ifdef FETCH_PERF_CNT_EN
    // Count every sequential capture; free-running wrap.
    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_count <= '0;
        end else if (load) begin
            fetch_count <= fetch_count + 32'd1;
        end
    end
`endif

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage. Owns the program counter and drives `read_address` of instruction_memory.
- Captures the returned instruction into the IF/ID pipeline register for decode.
- Handles hazard stalls, branch/jump redirects with flush, and a fetch-halt state machine.
- instruction_memory is combinational, byte-addressed and big-endian; this block supplies all sequencing around it.

Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- HALT_INSN, 32'h0000_000D: MIPS BREAK encoding; fetching it halts fetch.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- stall  in  1  hazard unit request; hold PC and IF/ID.
- branch_taken  in  1  branch resolved taken in EX.
- branch_target  in  32  branch destination byte address.
- jump  in  1  jump decoded in ID.
- jump_target  in  32  jump destination byte address.
- imem_instruction  in  32  instruction_memory `instruction` output.
- imem_address  out  32  to instruction_memory `read_address`; equals PC.
- if_id_instruction  out  32  registered instruction for decode.
- if_id_pc_plus4  out  32  registered PC+4 of that instruction.
- if_id_valid  out  1  IF/ID holds a real instruction.
- halted  out  1  state == HALT.
- misaligned  out  1  sticky: redirect target had addr[1:0] != 0.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-low (rst == 0 sampled at posedge clk).
- Reset values: PC = RESET_PC, if_id_instruction = 0, if_id_pc_plus4 = 0, if_id_valid = 0, misaligned = 0, state = BOOT, halted = 0. Reset overrides every other input.
- imem_address = PC, combinationally. The instruction is sampled in the same cycle (zero-latency memory). Fetch-to-IF/ID latency is 1 cycle.
- States: BOOT, RUN, HALT.
  - BOOT: exactly 1 cycle after reset deassert. No capture, PC held, if_id_valid = 0. Next state RUN. Redirect inputs are ignored in BOOT.
  - RUN, per-cycle priority (first match wins):
    1. branch_taken
    2. jump
    3. stall
    4. sequential
  - Redirect (branch_taken or jump): PC <= selected target. IF/ID flushed: instruction = 0, pc_plus4 = 0, valid = 0. Redirect overrides stall. branch_taken beats jump when both are asserted (branch is the older instruction).
  - Misaligned redirect: target[1:0] != 0 -> misaligned <= 1, state <= HALT, PC unchanged, IF/ID flushed.
  - stall (no redirect): PC and all IF/ID fields hold their values.
  - Sequential: IF/ID <= {imem_instruction, PC+4, valid = 1}; PC <= PC+4. PC+4 wraps modulo 2^32.
  - If imem_instruction == HALT_INSN on a sequential capture: it is captured with valid = 1, PC is not advanced, state <= HALT.
- HALT:
  - halted = 1; PC held. The next non-stalled cycle clears if_id_valid (the halt instruction drains). Stall still holds IF/ID.
  - An aligned redirect exits HALT: PC <= target, flush, state <= RUN, because the halt was speculative behind an older branch.
  - After a misaligned fault, HALT is left only by reset; redirects are ignored while misaligned = 1.
- Reset mid-operation: next edge with rst == 0 restores all reset values, regardless of state or stall.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
  - Defined: extra output fetch_count, 32 bits, reset 0. Increments on every sequential capture with valid = 1. Wraps at 2^32 and never saturates.
  - Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package mips_pkg:
  - constants: WORD_BYTES = 4, HALT_INSN default, NOP = 32'h0;
  - state enum fetch_state_t {BOOT, RUN, HALT};
  - widths ADDR_W = 32, INSN_W = 32.
- One natural sub-module: if_id_reg. It holds instruction, pc_plus4 and valid, with load, hold and flush controls. The top holds the PC, next-PC mux and FSM.

Test Plan:
- Reset then free run, RESET_PC = 0, memory words A, B, C at 0, 4, 8 -> BOOT 1 cycle, then IF/ID = {A, 4}, {B, 8}, {C, 12} on successive cycles, valid = 1.
- stall high 2 cycles while IF/ID = {B, 8} -> PC = 8 and IF/ID unchanged for 2 cycles, then {C, 12}.
- branch_taken = 1 and jump = 1 in the same cycle, with stall = 1, branch_target = 0x10, jump_target = 0x20 -> PC = 0x10, IF/ID flushed with valid = 0, next capture has pc_plus4 = 0x14.
- Fetch 0x0000000D at PC 8 -> captured valid, halted = 1, PC stays 8, next cycle valid = 0. Then branch_taken with target 0x4 -> RUN, PC = 4.
- jump_target = 0x6 -> misaligned = 1, halted = 1. A later aligned branch is ignored. rst low for 1 edge -> all outputs return to reset values.
- With FETCH_PERF_CNT_EN defined: 5 sequential captures, 1 stall and 1 flush -> fetch_count = 5.
